// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default data-memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 3072;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_master_if.sv
// Request/response channel between the pipeline MEM stage (master) and the
// load/store unit (slave).
interface lsu_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts/extends a loaded sub-word and merges a
// sub-word store into the full memory word. Misaligned low bits are ignored.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = word[{off, 3'b000} +: 8];
    h     = off[1] ? word[31:16] : word[15:0];
    ldata = word;
    mdata = wdata;
    case (size)
      SZ_BYTE: begin
        ldata = {{24{sign & b[7]}}, b};
        mdata = word;
        mdata[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata = {{16{sign & h[15]}}, h};
        mdata = word;
        if (off[1]) mdata[31:16] = wdata[15:0];
        else        mdata[15:0]  = wdata[15:0];
      end
      default: begin
        ldata = word;
        mdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator for the word-wide data memory; sub-word stores use
// read-modify-write. Define LSU_ERR_EN to reject misaligned half/word accesses.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int          MEM_WORDS = MEM_WORDS_DEF,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  lsu_master_if.slave bus,
  output logic [31:0] memAdr,
  output logic        memWrite,
  output logic [31:0] wdata,
  output logic [31:0] wPc,
  input  logic [31:0] memOut
);

  lsu_state_t  state, nstate;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q, wbuf_q;
  logic [1:0]  size_q;
  logic        sign_q, err_q;
  logic        req_err;
  logic [31:0] ldata, mdata;

  lsu_lane u_lane (
    .word  (memOut),
    .off   (addr_q[1:0]),
    .size  (size_q),
    .sign  (sign_q),
    .wdata (wdata_q),
    .ldata (ldata),
    .mdata (mdata)
  );

  always_comb begin
    req_err = (bus.req_size == 2'd3) || (bus.req_addr[31:2] >= 30'(MEM_WORDS));
`ifdef LSU_ERR_EN
    if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
        (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  always_comb begin
    nstate         = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && err_q;
    bus.resp_rdata = rdata_q;
    memWrite       = (state == WRITE);
    memAdr         = {addr_q[31:2], 2'b00};
    wdata          = wbuf_q;
    wPc            = (state == WRITE) ? pc_q : RESET_PC;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                     nstate = RESP;
          else if (!bus.req_we)            nstate = LOAD;
          else if (bus.req_size == SZ_WORD) nstate = WRITE;
          else                             nstate = RMW;
        end
      end
      LOAD:    nstate = RESP;
      RMW:     nstate = WRITE;
      WRITE:   nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // memWrite decodes straight from state, so an asynchronous reset drops it at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wbuf_q  <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            pc_q    <= bus.req_pc;
            size_q  <= bus.req_size;
            sign_q  <= bus.req_sign;
            err_q   <= req_err;
            rdata_q <= '0;
            if (bus.req_we && bus.req_size == SZ_WORD && !req_err)
              wbuf_q <= bus.req_wdata;
          end
        end
        LOAD:    rdata_q <= ldata;
        RMW:     wbuf_q  <= mdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: directed table, reset-abort sequences and random
// traffic against a byte-addressed reference memory.
module tb_lsu_master;
  import lsu_pkg::*;

  localparam int          MW  = 3072;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] memAdr, wdata, wPc, memOut;
  logic        memWrite;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  lsu_master_if bus();

  lsu_master #(.MEM_WORDS(MW), .RESET_PC(RPC)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus.slave),
    .memAdr   (memAdr),
    .memWrite (memWrite),
    .wdata    (wdata),
    .wPc      (wPc),
    .memOut   (memOut)
  );

  // Data memory seen by the DUT
  logic [31:0] mem [0:MW-1];
  always_comb memOut = (memAdr[31:2] < 30'(MW)) ? mem[memAdr[13:2]] : 32'h0;
  always @(posedge clk)
    if (memWrite && memAdr[31:2] < 30'(MW)) mem[memAdr[13:2]] <= wdata;

  // Reference model: byte-addressed storage
  logic [7:0] rb [int];

  function automatic logic [7:0] rd_byte(input int a);
    return rb.exists(a) ? rb[a] : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] <= v;
    for (int i = 0; i < 4; i++) rb[idx*4 + i] = v[8*i +: 8];
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_err,
                       output int e_lat, output int e_nwr);
    int unsigned n, base;
    logic [31:0] v;
    e_rd  = 32'h0;
    e_nwr = 0;
    e_err = (size == 2'd3) || ((addr >> 2) >= MW);
`ifdef LSU_ERR_EN
    if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) e_err = 1'b1;
`endif
    if (e_err) begin
      e_lat = 1;
      return;
    end
    n    = 32'd1 << size;
    base = addr - (addr % n);
    if (we) begin
      for (int i = 0; i < int'(n); i++) rb[int'(base) + i] = wd[8*i +: 8];
      e_nwr = 1;
      e_lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(rd_byte(int'(base) + i)) << (8*i));
      if (sign && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      e_rd  = v;
      e_lat = 2;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nwr, output logic [31:0] wa, output logic [31:0] wdv,
                        output logic [31:0] wpv);
    lat = 99; rd = 32'h0; er = 1'b0; nwr = 0; wa = 32'h0; wdv = 32'h0; wpv = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_sign = sign;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_pc = pc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memWrite) begin
        nwr++; wa = memAdr; wdv = wdata; wpv = wPc;
      end
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    chk("ready_after_resp", 32'(bus.req_ready), 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          lat, nwr, e_lat, e_nwr, r, idx;
    logic [31:0] rd, wa, wdv, wpv, e_rd, a, w;
    logic        er, e_err, we, sg;
    logic [1:0]  sz;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_sign = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_pc = 32'h0;
    for (int i = 0; i < MW; i++) mem[i] <= 32'h0;

    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_memWrite", 32'(memWrite), 32'h0);
    chk("rst_memAdr", memAdr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wPc", wPc, RPC);
    @(negedge clk); rst_n = 1'b1;

    // Word store: WRITE cycle contents and latency
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h3000, lat, rd, er, nwr, wa, wdv, wpv);
    model(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, e_rd, e_err, e_lat, e_nwr);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'h0);
    chk("sw_nwr", 32'(nwr), 32'd1);
    chk("sw_memAdr", wa, 32'h10);
    chk("sw_wdata", wdv, 32'hDEADBEEF);
    chk("sw_wPc", wdv == 32'hDEADBEEF ? wpv : 32'hX, 32'h3000);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("idle_wPc", wPc, RPC);

    poke(4, 32'h8899AABB);
    tbl.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0});
    tbl.push_back('{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0});
    tbl.push_back('{1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0});
    tbl.push_back('{1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, 2'd3,    1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h2FFC, 32'h0, 32'h0, 1'b0, 2, 0});
    tbl.push_back('{1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h55, 32'h0, 1'b0, 3, 1});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 0});
`ifdef LSU_ERR_EN
    tbl.push_back('{1'b1, SZ_HALF, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 0});
`else
    tbl.push_back('{1'b1, SZ_HALF, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b0, 3, 1});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h88991234, 1'b0, 2, 0});
`endif
    tbl.push_back('{1'b1, SZ_WORD, 1'b0, 32'h2FFC, 32'h0BADF00D, 32'h0, 1'b0, 2, 1});
    tbl.push_back('{1'b0, SZ_WORD, 1'b0, 32'h2FFC, 32'h0, 32'h0BADF00D, 1'b0, 2, 0});
    tbl.push_back('{1'b1, SZ_BYTE, 1'b0, 32'h3001, 32'h66, 32'h0, 1'b1, 1, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wd, e_rd, e_err, e_lat, e_nwr);
      do_req(tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wd, 32'h4000 + 32'(i),
             lat, rd, er, nwr, wa, wdv, wpv);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_nwr", i), 32'(nwr), 32'(tbl[i].nwr));
    end

    // Reset during RMW: access aborted, then back-to-back requests work
    poke(8, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_sign = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'hAA; bus.req_pc = 32'h5000;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_busy_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_memWrite", 32'(memWrite), 32'h0);
    chk("rmw_rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rmw_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    chk("rmw_abort_mem", mem[8], 32'h11223344);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, lat, rd, er, nwr, wa, wdv, wpv);
    chk("after_rst_lw", rd, 32'h11223344);
    chk("after_rst_lat", 32'(lat), 32'd2);
    model(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h77, e_rd, e_err, e_lat, e_nwr);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h77, 32'h0, lat, rd, er, nwr, wa, wdv, wpv);
    chk("after_rst_sb_lat", 32'(lat), 32'd3);
    chk("after_rst_sb_wdata", wdv, 32'h11773344);

    // Reset during WRITE: strobe must drop before the next edge
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h24; bus.req_wdata = 32'hCAFEF00D; bus.req_pc = 32'h6000;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("wr_state_memWrite", 32'(memWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_memWrite", 32'(memWrite), 32'h0);
    chk("wr_rst_wPc", wPc, RPC);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    chk("wr_abort_mem", mem[9], 32'h0);

    // Random traffic against the reference model
    for (int it = 0; it < 300; it++) begin
      r   = int'($urandom_range(0, 9));
      idx = (r == 0) ? int'($urandom_range(3068, 3075)) : int'($urandom_range(0, 15));
      a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      w   = $urandom;
      model(we, sz, sg, a, w, e_rd, e_err, e_lat, e_nwr);
      do_req(we, sz, sg, a, w, $urandom, lat, rd, er, nwr, wa, wdv, wpv);
      chk($sformatf("rnd%0d_rdata", it), rd, e_rd);
      chk($sformatf("rnd%0d_err", it), 32'(er), 32'(e_err));
      chk($sformatf("rnd%0d_lat", it), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_nwr", it), 32'(nwr), 32'(e_nwr));
    end

    for (int k = 0; k < 20; k++) begin
      idx = (k < 16) ? k : 3052 + k;
      w = {rd_byte(idx*4+3), rd_byte(idx*4+2), rd_byte(idx*4+1), rd_byte(idx*4)};
      chk($sformatf("final_mem%0d", idx), mem[idx], w);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator that drives the data-memory port: memAdr, memWrite, wdata, wPc out; memOut in, read combinationally in the same cycle.
- Accepts byte, halfword and word requests from the pipeline MEM stage over a valid/ready handshake.
- Loads: extracts and sign- or zero-extends the addressed lanes.
- Sub-word stores: read-modify-write on full words, since memory writes whole words only.
- Returns a one-cycle response pulse.

Parameters:
- MEM_WORDS, 3072, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.
- RESET_PC, 32'h0000_0000, value driven on wPc while idle and after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_pc  in  32  PC of the instruction, forwarded to wPc
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; access rejected
- memAdr  out  32  word-aligned byte address, low 2 bits always 0
- memWrite  out  1  memory write strobe
- wdata  out  32  full word to write
- wPc  out  32  PC tag for the store trace
- memOut  in  32  combinational read data at memAdr

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - memWrite=0, memAdr=0, wdata=0, wPc=RESET_PC; all internal request registers cleared.
  - Reset asserted mid-operation aborts the access with no memory write. Once reset is asserted, memWrite must be 0 before the next clock edge.
- Handshake:
  - A request is accepted on a rising edge with req_valid=1 and req_ready=1; addr, size, we, sign, wdata and pc are registered.
  - Request inputs are ignored outside IDLE.
  - resp_valid has no backpressure.
- FSM states: IDLE, LOAD, RMW, WRITE, RESP.
- Transitions from IDLE on accept:
  - error → RESP with err=1
  - load → LOAD
  - store word → WRITE
  - store byte/half → RMW
- Other transitions:
  - LOAD: memAdr={addr[31:2],2'b00}, memWrite=0; capture extracted and extended memOut → RESP.
  - RMW: same memAdr, memWrite=0; latch memOut into merge buffer → WRITE.
  - WRITE: memWrite=1; wdata = merged word (sub-word) or req_wdata (word); wPc=req_pc → RESP. The memory commits on the edge leaving WRITE.
  - RESP: resp_valid=1 for exactly one cycle → IDLE. req_ready becomes 1 in the following cycle.
- Latency, counted from accept edge to the cycle resp_valid=1:
  - load 2 cycles
  - word store 2 cycles
  - sub-word store 3 cycles
  - error 1 cycle
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], k=addr[1:0]
  - half = bits [15:0] if addr[1]=0, else [31:16]
- Sub-word merge replaces only the addressed lanes with req_wdata[7:0] or [15:0]; all other lanes keep their memOut value.
- Error conditions (checked in IDLE at accept):
  - size=3
  - word index (addr[31:2]) >= MEM_WORDS
  - misalignment, when LSU_ERR_EN is defined (see Optional Feature)
- On error: no memory access, memWrite stays 0, resp_rdata=0.
- Outside WRITE: memWrite=0 and wdata holds its last value.

Optional Feature:
- Macro LSU_ERR_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, is a misaligned access → error response, no memory access.
- Undefined: misaligned low bits are silently truncated; half uses addr[1], word ignores addr[1:0]. The access proceeds normally.
- Range and size=3 errors are always active.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum for IDLE/LOAD/RMW/WRITE/RESP
  - default MEM_WORDS
- One natural sub-module, lsu_lane: purely combinational; does both load extraction/extension and store merge from (word, addr[1:0], size, sign, wdata). It is reused by LOAD and RMW.

Test Plan:
1. Reset release; word store addr=0x10, wdata=0xDEADBEEF, pc=0x3000 → WRITE cycle shows memAdr=0x10, memWrite=1, wdata=0xDEADBEEF, wPc=0x3000; resp_valid 2 cycles after accept, err=0.
2. Memory word 0x10 = 0x8899AABB:
   - signed byte load addr=0x13 → resp_rdata=0xFFFFFF88
   - unsigned half load addr=0x12 → 0x00008899
   - word load → 0x8899AABB
3. Memory word 0x10 = 0x8899AABB; sb addr=0x11, wdata=0x55 → RMW then WRITE with wdata=0x8899_55BB; resp_valid 3 cycles after accept.
4. Word load addr=0x3000 (index 3072, out of range) → resp_err=1, resp_rdata=0, memWrite never asserted.
5. With LSU_ERR_EN: half store addr=0x11 → resp_err=1, no write. Without LSU_ERR_EN: same request writes lanes [15:0] of word 0x10.
6. Assert reset during the RMW cycle of a sub-word store → memWrite=0 immediately, no write occurs, state IDLE, req_ready=1; a back-to-back request after release completes correctly.
